// File: rtl/ysyx_24110015_axi_arbiter_if.sv
// AXI4 channel bundle shared by the IFU, LSU and downstream ports of the arbiter.
interface axi_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 4
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;

    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic [ID_W-1:0]   rid;
    logic              rvalid;
    logic              rready;

    logic [ADDR_W-1:0] awaddr;
    logic [ID_W-1:0]   awid;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [1:0]        bresp;
    logic [ID_W-1:0]   bid;
    logic              bvalid;
    logic              bready;

    modport master (
        output araddr, arid, arlen, arsize, arburst, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rid, rvalid,
        output rready,
        output awaddr, awid, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bid, bvalid,
        output bready
    );

    modport slave (
        input  araddr, arid, arlen, arsize, arburst, arvalid,
        output arready,
        output rdata, rresp, rlast, rid, rvalid,
        input  rready,
        input  awaddr, awid, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bid, bvalid,
        input  bready
    );
endinterface

// File: rtl/ysyx_24110015_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4 arbiter, grant held per transaction.
// Optional ARB_ROUND_ROBIN_EN: alternate IFU/LSU on contention instead of fixed LSU priority.
module ysyx_24110015_axi_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic clk,
    input  logic rst,
    axi_if.slave  ifu,
    axi_if.slave  lsu,
    axi_if.master mem
);

    typedef enum logic [1:0] {IDLE, IFU_R, LSU_R, LSU_W} state_t;

    state_t state;
    state_t state_nxt;

    logic lsu_req;
    state_t lsu_pick;

    assign lsu_req  = lsu.awvalid | lsu.arvalid;
    assign lsu_pick = lsu.awvalid ? LSU_W : LSU_R;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

`ifdef ARB_ROUND_ROBIN_EN
    // 1: LSU wins the next IFU/LSU contention, 0: IFU wins
    logic lsu_fav;
    logic lsu_fav_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lsu_fav <= 1'b0;
        else     lsu_fav <= lsu_fav_nxt;
    end
`endif

    // Grant decision in IDLE, release on the last read beat or the write response
    always_comb begin
        state_nxt = state;
`ifdef ARB_ROUND_ROBIN_EN
        lsu_fav_nxt = lsu_fav;
`endif
        case (state)
            IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
                if (lsu_req && (!ifu.arvalid || lsu_fav)) begin
                    state_nxt   = lsu_pick;
                    lsu_fav_nxt = 1'b0;
                end else if (ifu.arvalid) begin
                    state_nxt   = IFU_R;
                    lsu_fav_nxt = 1'b1;
                end
`else
                if (lsu_req)          state_nxt = lsu_pick;
                else if (ifu.arvalid) state_nxt = IFU_R;
`endif
            end
            IFU_R: if (mem.rvalid && ifu.rready && mem.rlast) state_nxt = IDLE;
            LSU_R: if (mem.rvalid && lsu.rready && mem.rlast) state_nxt = IDLE;
            LSU_W: if (mem.bvalid && lsu.bready)              state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Channel mux: only the owner is connected, everything else is held at zero
    always_comb begin
        mem.araddr  = '0;
        mem.arid    = '0;
        mem.arlen   = '0;
        mem.arsize  = '0;
        mem.arburst = '0;
        mem.arvalid = 1'b0;
        mem.rready  = 1'b0;
        mem.awaddr  = '0;
        mem.awid    = '0;
        mem.awlen   = '0;
        mem.awsize  = '0;
        mem.awburst = '0;
        mem.awvalid = 1'b0;
        mem.wdata   = '0;
        mem.wstrb   = '0;
        mem.wlast   = 1'b0;
        mem.wvalid  = 1'b0;
        mem.bready  = 1'b0;

        ifu.arready = 1'b0;
        ifu.rdata   = '0;
        ifu.rresp   = '0;
        ifu.rlast   = 1'b0;
        ifu.rid     = '0;
        ifu.rvalid  = 1'b0;
        ifu.awready = 1'b0;
        ifu.wready  = 1'b0;
        ifu.bresp   = '0;
        ifu.bid     = '0;
        ifu.bvalid  = 1'b0;

        lsu.arready = 1'b0;
        lsu.rdata   = '0;
        lsu.rresp   = '0;
        lsu.rlast   = 1'b0;
        lsu.rid     = '0;
        lsu.rvalid  = 1'b0;
        lsu.awready = 1'b0;
        lsu.wready  = 1'b0;
        lsu.bresp   = '0;
        lsu.bid     = '0;
        lsu.bvalid  = 1'b0;

        case (state)
            IFU_R: begin
                mem.araddr  = ADDR_W'(ifu.araddr);
                mem.arid    = ifu.arid;
                mem.arlen   = ifu.arlen;
                mem.arsize  = ifu.arsize;
                mem.arburst = ifu.arburst;
                mem.arvalid = ifu.arvalid;
                ifu.arready = mem.arready;
                ifu.rdata   = DATA_W'(mem.rdata);
                ifu.rresp   = mem.rresp;
                ifu.rlast   = mem.rlast;
                ifu.rid     = mem.rid;
                ifu.rvalid  = mem.rvalid;
                mem.rready  = ifu.rready;
            end
            LSU_R: begin
                mem.araddr  = ADDR_W'(lsu.araddr);
                mem.arid    = lsu.arid;
                mem.arlen   = lsu.arlen;
                mem.arsize  = lsu.arsize;
                mem.arburst = lsu.arburst;
                mem.arvalid = lsu.arvalid;
                lsu.arready = mem.arready;
                lsu.rdata   = DATA_W'(mem.rdata);
                lsu.rresp   = mem.rresp;
                lsu.rlast   = mem.rlast;
                lsu.rid     = mem.rid;
                lsu.rvalid  = mem.rvalid;
                mem.rready  = lsu.rready;
            end
            LSU_W: begin
                mem.awaddr  = ADDR_W'(lsu.awaddr);
                mem.awid    = lsu.awid;
                mem.awlen   = lsu.awlen;
                mem.awsize  = lsu.awsize;
                mem.awburst = lsu.awburst;
                mem.awvalid = lsu.awvalid;
                lsu.awready = mem.awready;
                mem.wdata   = DATA_W'(lsu.wdata);
                mem.wstrb   = lsu.wstrb;
                mem.wlast   = lsu.wlast;
                mem.wvalid  = lsu.wvalid;
                lsu.wready  = mem.wready;
                lsu.bresp   = mem.bresp;
                lsu.bid     = mem.bid;
                lsu.bvalid  = mem.bvalid;
                mem.bready  = lsu.bready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_24110015_axi_arbiter.sv
// Bench for the IFU/LSU AXI arbiter: behavioural slave, scoreboarded responses, timing checks.
module tb_ysyx_24110015_axi_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned B_LAT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi_if #(.ADDR_W(AW), .DATA_W(DW)) ifu_bus ();
    axi_if #(.ADDR_W(AW), .DATA_W(DW)) lsu_bus ();
    axi_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

    ysyx_24110015_axi_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .ifu (ifu_bus),
        .lsu (lsu_bus),
        .mem (mem_bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] rd_data(input logic [31:0] addr, input int beat);
        if (addr == 32'h3000_0004 && beat == 0) return 32'hDEADBEEF;
        return (addr + 32'(beat) * 32'd4) ^ 32'hA5A5_0000;
    endfunction

    // ---------------- behavioural slave ----------------
    logic        s_rbusy, s_rvalid, inj_rvalid;
    logic [31:0] s_raddr;
    logic [7:0]  s_rlen, s_rbeat;
    int          s_rcnt;

    assign mem_bus.arready = !s_rbusy;
    assign mem_bus.rvalid  = s_rvalid | inj_rvalid;
    assign mem_bus.rdata   = s_rvalid ? rd_data(s_raddr, int'(s_rbeat)) : 32'h0;
    assign mem_bus.rlast   = s_rvalid && (s_rbeat == s_rlen);
    assign mem_bus.rresp   = 2'b00;
    assign mem_bus.rid     = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_rbusy <= 1'b0; s_rvalid <= 1'b0; s_raddr <= '0;
            s_rlen <= '0; s_rbeat <= '0; s_rcnt <= 0;
        end else if (mem_bus.arvalid && mem_bus.arready) begin
            s_rbusy <= 1'b1; s_raddr <= mem_bus.araddr; s_rlen <= mem_bus.arlen;
            s_rbeat <= '0; s_rcnt <= RD_LAT;
        end else if (s_rbusy && !s_rvalid) begin
            if (s_rcnt != 0) s_rcnt <= s_rcnt - 1;
            else             s_rvalid <= 1'b1;
        end else if (s_rvalid && mem_bus.rready) begin
            if (s_rbeat == s_rlen) begin
                s_rvalid <= 1'b0; s_rbusy <= 1'b0;
            end else begin
                s_rbeat <= s_rbeat + 8'd1;
            end
        end
    end

    logic        s_wbusy, s_got_w, s_bvalid;
    int          s_bcnt;
    logic [31:0] cap_awaddr, cap_wdata;
    logic [3:0]  cap_wstrb;
    logic        cap_wlast;

    assign mem_bus.awready = !s_wbusy;
    assign mem_bus.wready  = s_wbusy && !s_got_w;
    assign mem_bus.bvalid  = s_bvalid;
    assign mem_bus.bresp   = 2'b00;
    assign mem_bus.bid     = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_wbusy <= 1'b0; s_got_w <= 1'b0; s_bvalid <= 1'b0; s_bcnt <= 0;
            cap_awaddr <= '0; cap_wdata <= '0; cap_wstrb <= '0; cap_wlast <= 1'b0;
        end else if (mem_bus.awvalid && mem_bus.awready) begin
            s_wbusy <= 1'b1; s_got_w <= 1'b0; cap_awaddr <= mem_bus.awaddr;
        end else if (mem_bus.wvalid && mem_bus.wready) begin
            s_got_w <= 1'b1; cap_wdata <= mem_bus.wdata; cap_wstrb <= mem_bus.wstrb;
            cap_wlast <= mem_bus.wlast; s_bcnt <= B_LAT;
        end else if (s_got_w && !s_bvalid && s_wbusy) begin
            if (s_bcnt != 0) s_bcnt <= s_bcnt - 1;
            else             s_bvalid <= 1'b1;
        end else if (s_bvalid && mem_bus.bready) begin
            s_bvalid <= 1'b0; s_wbusy <= 1'b0;
        end
    end

    // ---------------- scoreboard and monitors ----------------
    logic [32:0] ifu_q[$];
    logic [32:0] lsu_q[$];
    logic [1:0]  lsu_b_q[$];

    int ifu_ar_cyc, lsu_ar_cyc, ifu_rlast_cyc, lsu_rlast_cyc, lsu_b_cyc;
    int ifu_rv_cnt = 0, lsu_rv_cnt = 0, ifu_beats = 0;

    always @(negedge clk) begin
        logic [32:0] e;
        logic [1:0]  eb;
        if (ifu_bus.arvalid && ifu_bus.arready) ifu_ar_cyc = cyc;
        if (lsu_bus.arvalid && lsu_bus.arready) lsu_ar_cyc = cyc;
        if (ifu_bus.rvalid) ifu_rv_cnt++;
        if (lsu_bus.rvalid) lsu_rv_cnt++;
        if (ifu_bus.rvalid && ifu_bus.rready) begin
            ifu_beats++;
            if (ifu_bus.rlast) ifu_rlast_cyc = cyc;
            if (ifu_q.size() == 0) check("ifu_unexpected_beat", 1, 0);
            else begin
                e = ifu_q.pop_front();
                check("ifu_rbeat", {ifu_bus.rlast, ifu_bus.rdata}, e);
            end
        end
        if (lsu_bus.rvalid && lsu_bus.rready) begin
            if (lsu_bus.rlast) lsu_rlast_cyc = cyc;
            if (lsu_q.size() == 0) check("lsu_unexpected_beat", 1, 0);
            else begin
                e = lsu_q.pop_front();
                check("lsu_rbeat", {lsu_bus.rlast, lsu_bus.rdata}, e);
            end
        end
        if (lsu_bus.bvalid && lsu_bus.bready) begin
            lsu_b_cyc = cyc;
            if (lsu_b_q.size() == 0) check("lsu_unexpected_b", 1, 0);
            else begin
                eb = lsu_b_q.pop_front();
                check("lsu_bresp", lsu_bus.bresp, eb);
            end
        end
    end

    // ---------------- master drivers ----------------
    task automatic ifu_read(input logic [31:0] addr, input logic [7:0] len);
        int  t = 0;
        bit  hs = 0;
        @(posedge clk); #1;
        ifu_bus.araddr = addr; ifu_bus.arlen = len; ifu_bus.arsize = 3'd2;
        ifu_bus.arburst = 2'b01; ifu_bus.arvalid = 1'b1;
        for (int b = 0; b <= int'(len); b++) ifu_q.push_back({b == int'(len), rd_data(addr, b)});
        while (!hs) begin
            @(negedge clk); hs = ifu_bus.arvalid && ifu_bus.arready;
            @(posedge clk); #1;
            if (++t > 300) begin check("ifu_ar_timeout", 0, 1); break; end
        end
        ifu_bus.arvalid = 1'b0;
    endtask

    task automatic lsu_read(input logic [31:0] addr, input logic [7:0] len);
        int  t = 0;
        bit  hs = 0;
        @(posedge clk); #1;
        lsu_bus.araddr = addr; lsu_bus.arlen = len; lsu_bus.arsize = 3'd2;
        lsu_bus.arburst = 2'b01; lsu_bus.arvalid = 1'b1;
        for (int b = 0; b <= int'(len); b++) lsu_q.push_back({b == int'(len), rd_data(addr, b)});
        while (!hs) begin
            @(negedge clk); hs = lsu_bus.arvalid && lsu_bus.arready;
            @(posedge clk); #1;
            if (++t > 300) begin check("lsu_ar_timeout", 0, 1); break; end
        end
        lsu_bus.arvalid = 1'b0;
    endtask

    task automatic lsu_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int t = 0;
        bit a, w;
        bit a_done = 0, w_done = 0;
        @(posedge clk); #1;
        lsu_bus.awaddr = addr; lsu_bus.awlen = 8'd0; lsu_bus.awsize = 3'd2;
        lsu_bus.awburst = 2'b01; lsu_bus.awvalid = 1'b1;
        lsu_bus.wdata = data; lsu_bus.wstrb = strb; lsu_bus.wlast = 1'b1; lsu_bus.wvalid = 1'b1;
        lsu_b_q.push_back(2'b00);
        while (!(a_done && w_done)) begin
            @(negedge clk);
            a = lsu_bus.awvalid && lsu_bus.awready;
            w = lsu_bus.wvalid && lsu_bus.wready;
            @(posedge clk); #1;
            if (a) begin lsu_bus.awvalid = 1'b0; a_done = 1; end
            if (w) begin lsu_bus.wvalid = 1'b0; w_done = 1; end
            if (++t > 300) begin check("lsu_w_timeout", 0, 1); break; end
        end
        lsu_bus.awvalid = 1'b0;
        lsu_bus.wvalid  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t = 0;
        while (ifu_q.size() != 0 || lsu_q.size() != 0 || lsu_b_q.size() != 0) begin
            @(posedge clk);
            if (++t > 300) begin
                check(tag, 0, 1);
                ifu_q.delete(); lsu_q.delete(); lsu_b_q.delete();
                break;
            end
        end
    endtask

    function automatic logic [11:0] hs_vec();
        return {mem_bus.arvalid, mem_bus.awvalid, mem_bus.wvalid, mem_bus.rready, mem_bus.bready,
                ifu_bus.arready, ifu_bus.rvalid, lsu_bus.arready, lsu_bus.awready,
                lsu_bus.wready, lsu_bus.rvalid, lsu_bus.bvalid};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    initial begin
        int base, rv0;
        inj_rvalid = 1'b0;
        ifu_bus.araddr = '0; ifu_bus.arid = '0; ifu_bus.arlen = '0; ifu_bus.arsize = '0;
        ifu_bus.arburst = '0; ifu_bus.arvalid = 1'b0; ifu_bus.rready = 1'b1;
        ifu_bus.awaddr = '0; ifu_bus.awid = '0; ifu_bus.awlen = '0; ifu_bus.awsize = '0;
        ifu_bus.awburst = '0; ifu_bus.awvalid = 1'b0; ifu_bus.wdata = '0; ifu_bus.wstrb = '0;
        ifu_bus.wlast = 1'b0; ifu_bus.wvalid = 1'b0; ifu_bus.bready = 1'b0;
        lsu_bus.araddr = '0; lsu_bus.arid = '0; lsu_bus.arlen = '0; lsu_bus.arsize = '0;
        lsu_bus.arburst = '0; lsu_bus.arvalid = 1'b0; lsu_bus.rready = 1'b1;
        lsu_bus.awaddr = '0; lsu_bus.awid = '0; lsu_bus.awlen = '0; lsu_bus.awsize = '0;
        lsu_bus.awburst = '0; lsu_bus.awvalid = 1'b0; lsu_bus.wdata = '0; lsu_bus.wstrb = '0;
        lsu_bus.wlast = 1'b0; lsu_bus.wvalid = 1'b0; lsu_bus.bready = 1'b1;

        // Reset state, including the first cycle after release
        ifu_bus.arvalid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_handshakes", hs_vec(), 12'h0);
        check("rst_state", 64'(dut.state), 0);
        @(posedge clk); #1 rst = 1'b0; ifu_bus.arvalid = 1'b0;
        @(negedge clk);
        check("post_rst_handshakes", hs_vec(), 12'h0);

        // Lone IFU single read
        ifu_rv_cnt = 0; lsu_rv_cnt = 0;
        fork
            ifu_read(32'h3000_0004, 8'd0);
            begin
                @(posedge clk); #1;
                @(negedge clk); check("t1_mem_arvalid_N", mem_bus.arvalid, 0);
                @(negedge clk); check("t1_mem_arvalid_N1", mem_bus.arvalid, 1);
                check("t1_ifu_arready_N1", ifu_bus.arready, 1);
            end
        join
        wait_done("t1_done_timeout");
        @(negedge clk);
        check("t1_ifu_rvalid_cycles", ifu_rv_cnt, 1);
        check("t1_lsu_rvalid_cycles", lsu_rv_cnt, 0);
        check("t1_state_idle", 64'(dut.state), 0);

        // IFU 4-beat burst with an LSU read raised during beat 2
        base = ifu_beats;
        fork
            ifu_read(32'hA000_0000, 8'd3);
            begin
                int t = 0;
                while (ifu_beats < base + 2 && t < 300) begin @(posedge clk); t++; end
                lsu_read(32'h8000_0100, 8'd0);
            end
        join
        wait_done("t2_done_timeout");
        check("t2_ifu_beats", ifu_beats - base, 4);
        check("t2_lsu_ar_after_rlast", lsu_ar_cyc - ifu_rlast_cyc, 2);

        // Simultaneous IFU and LSU read requests
        repeat (2) @(posedge clk);
        fork
            ifu_read(32'h3000_0100, 8'd0);
            lsu_read(32'h8000_0200, 8'd0);
        join
        wait_done("t3_done_timeout");
`ifdef ARB_ROUND_ROBIN_EN
        check("t3_ifu_first", ifu_ar_cyc < lsu_ar_cyc, 1);
        check("t3_second_gap", lsu_ar_cyc - ifu_rlast_cyc, 2);
`else
        check("t3_lsu_first", lsu_ar_cyc < ifu_ar_cyc, 1);
        check("t3_second_gap", ifu_ar_cyc - lsu_rlast_cyc, 2);
`endif

        // LSU store with an IFU read arriving while the write owns the bus
        repeat (2) @(posedge clk);
        fork
            lsu_write(32'h8000_0010, 32'h1234_5678, 4'hF);
            begin
                @(posedge clk); @(posedge clk);
                ifu_read(32'h3000_0008, 8'd0);
            end
        join
        wait_done("t4_done_timeout");
        check("t4_awaddr", cap_awaddr, 32'h8000_0010);
        check("t4_wdata", cap_wdata, 32'h1234_5678);
        check("t4_wstrb", cap_wstrb, 4'hF);
        check("t4_wlast", cap_wlast, 1);
        check("t4_ifu_waits_for_b", ifu_ar_cyc - lsu_b_cyc, 2);

        // Reset during the first beat of a 4-beat IFU burst
        repeat (2) @(posedge clk);
        ifu_read(32'hA000_0040, 8'd3);
        begin
            int t = 0;
            do begin @(negedge clk); t++; end while (!ifu_bus.rvalid && t < 300);
            if (t >= 300) check("t5_beat_timeout", 0, 1);
        end
        #1 rst = 1'b1;
        #1;
        check("t5_rst_handshakes", hs_vec(), 12'h0);
        check("t5_rst_state", 64'(dut.state), 0);
        ifu_q.delete();
        rv0 = ifu_rv_cnt;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t5_no_partial_resp", ifu_rv_cnt, rv0);
        base = ifu_beats;
        ifu_read(32'h3000_0004, 8'd0);
        wait_done("t5_done_timeout");
        check("t5_fresh_read_beats", ifu_beats - base, 1);

        // Stray mem.rvalid while IDLE
        repeat (2) @(posedge clk);
        #1 inj_rvalid = 1'b1;
        @(negedge clk);
        check("t6_rvalid_blocked", {ifu_bus.rvalid, lsu_bus.rvalid, mem_bus.rready}, 3'b000);
        @(posedge clk); #1 inj_rvalid = 1'b0;
        @(negedge clk);
        check("t6_state_idle", 64'(dut.state), 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
